req_ack_xfr_responder: RTL

Target-side responder for the req/ack/xfr burst handshake. It detects a rising edge on `req` and answers with a one-cycle `ack` no later than `MAX_ACK_LAT` clocks after the edge. It then drives `xfr` high for exactly `XFR_COUNT` consecutive cycles, each carrying one data word. Words are supplied by local logic through a small write-side FIFO. The block sits opposite the requester and its pReqAck/pAckDone assertions, and must satisfy both properties under all stimulus.

---
 rtl/req_ack_xfr_responder_if.sv | 36 +++
 rtl/req_ack_xfr_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/req_ack_xfr_responder_if.sv
// Bundle of the req/ack/xfr burst handshake plus the local write port.
//
// Handshake semantics:
//   - req/ack/xfr: the initiator raises req; only the 0->1 transition starts a
//     burst. The responder answers with a single-cycle ack, then holds xfr high
//     for a fixed number of back-to-back beats, each carrying xfr_data. There is
//     no back-pressure on beats.
//   - wr_valid/wr_ready: a word on wr_data is accepted on a rising clock edge
//     where wr_valid and wr_ready are both high. wr_valid may be raised without
//     waiting for wr_ready; a word offered while wr_ready is low is not taken.
interface req_ack_xfr_responder_if #(
   parameter int DATA_W = 8
);
   logic              req;
   logic              ack;
   logic              xfr;
   logic [DATA_W-1:0] xfr_data;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              busy;
   logic              underrun;
   logic              overlap;

   // Responder side.
   modport slave (
      input  req, wr_valid, wr_data,
      output ack, xfr, xfr_data, wr_ready, busy, underrun, overlap
   );

   // Initiator / local-logic side.
   modport master (
      output req, wr_valid, wr_data,
      input  ack, xfr, xfr_data, wr_ready, busy, underrun, overlap
   );
endinterface

// File: rtl/req_ack_xfr_responder.sv
// Target-side responder: detects a req rise, acks within MAX_ACK_LAT clocks,
// then streams XFR_COUNT beats out of a small write-side FIFO.
module req_ack_xfr_responder #(
   parameter int MAX_ACK_LAT = 4,
   parameter int XFR_COUNT   = 2,
   parameter int DEPTH       = 4,
   parameter int DATA_W      = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   req_ack_xfr_responder_if.slave     bus,
   output logic [1:0]                 dbg_state
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int WW = $clog2(MAX_ACK_LAT + 1);
   localparam int BW = (XFR_COUNT > 1) ? $clog2(XFR_COUNT) : 1;

   localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
   localparam logic [CW-1:0] NEED_C      = CW'(XFR_COUNT);
   localparam logic [WW-1:0] WAIT_LAST_C = WW'(MAX_ACK_LAT - 1);
   localparam logic [BW-1:0] BEAT_LAST_C = BW'(XFR_COUNT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_XFER = 2'd3
   } state_t;

   state_t            state, state_nx;
   logic              req_q;
   logic              rise;
   logic [WW-1:0]     wait_cnt, wait_cnt_nx;
   logic [BW-1:0]     beat_cnt, beat_cnt_nx;
   logic              underrun_nx;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count;
   logic              push, pop, data_ok, wr_ready_w;

   logic              ack_r, xfr_r, underrun_r, overlap_r;
   logic [DATA_W-1:0] xfr_data_r;

   assign rise       = bus.req & ~req_q;
   assign wr_ready_w = (count != DEPTH_C);
   assign push       = bus.wr_valid & wr_ready_w;
   assign data_ok    = (count >= NEED_C);
   // A beat is loaded on every edge that enters or stays in XFER; it only
   // consumes a word when one is buffered.
   assign pop        = (state_nx == S_XFER) && (count != '0);

   // Next-state, counters and underrun decision.
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      beat_cnt_nx = beat_cnt;
      underrun_nx = 1'b0;
      case (state)
         S_IDLE: begin
            if (rise) begin
               if (data_ok) begin
                  state_nx = S_ACK;
               end else if (MAX_ACK_LAT == 1) begin
                  state_nx    = S_ACK;
                  underrun_nx = 1'b1;
               end else begin
                  state_nx    = S_WAIT;
                  wait_cnt_nx = WW'(1);
               end
            end
         end
         S_WAIT: begin
            if (data_ok) begin
               state_nx = S_ACK;
            end else if (wait_cnt == WAIT_LAST_C) begin
               state_nx    = S_ACK;
               underrun_nx = 1'b1;
            end else begin
               wait_cnt_nx = wait_cnt + WW'(1);
            end
         end
         S_ACK: begin
            state_nx    = S_XFER;
            beat_cnt_nx = '0;
         end
         S_XFER: begin
            if (beat_cnt == BEAT_LAST_C) begin
               state_nx = S_IDLE;
            end else begin
               beat_cnt_nx = beat_cnt + BW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State register, edge detector and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         req_q      <= 1'b0;
         wait_cnt   <= '0;
         beat_cnt   <= '0;
         ack_r      <= 1'b0;
         xfr_r      <= 1'b0;
         xfr_data_r <= '0;
         underrun_r <= 1'b0;
         overlap_r  <= 1'b0;
      end else begin
         state      <= state_nx;
         req_q      <= bus.req;
         wait_cnt   <= wait_cnt_nx;
         beat_cnt   <= beat_cnt_nx;
         ack_r      <= (state_nx == S_ACK);
         xfr_r      <= (state_nx == S_XFER);
         xfr_data_r <= pop ? mem[rd_ptr] : '0;
         underrun_r <= underrun_nx;
         overlap_r  <= rise && (state != S_IDLE);
      end
   end

   // Circular FIFO: storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= bus.wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign bus.ack      = ack_r;
   assign bus.xfr      = xfr_r;
   assign bus.xfr_data = xfr_data_r;
   assign bus.wr_ready = wr_ready_w;
   assign bus.busy     = (state != S_IDLE);
   assign bus.underrun = underrun_r;
   assign bus.overlap  = overlap_r;
   assign dbg_state    = state;

endmodule
